// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: default data width, the canonical NOP
// and the fetch queue entry layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small first-word-fall-through FIFO of fetched {pc, instr} entries; the head
// is the IF/ID register. A flush empties it and wins over a same-cycle push.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    // Storage is not reset: stale slots are never visible because count gates them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory request
// in flight and feeds decode from fetch_queue. FETCH_PERF_EN adds push/drop counters.
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            ValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     FetchCount,
    output logic [31:0]     DropCount
`endif
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            discard_q, discard_d;

    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [CW:0]     occupancy;
    logic            valid, pop, req, accept, resp, drop, push;

    assign valid = (count != '0);
    assign pop   = valid && !StallD && !PCSrcE;

    // Slots already claimed by queued entries plus the one in flight, net of this cycle's pop.
    assign occupancy = {1'b0, count} + (CW+1)'(outstanding_q) - (CW+1)'(pop);

    assign req    = !reset && !PCSrcE && (!outstanding_q || imem_rvalid)
                    && (occupancy < (CW+1)'(DEPTH));
    assign accept = req && imem_ready;
    assign resp   = imem_rvalid && outstanding_q;
    assign drop   = resp && (discard_q || PCSrcE);
    assign push   = resp && !drop;

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (PCSrcE) begin
            fetch_pc_d = PCTargetE & ~XLEN'(3);
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (accept) begin
            req_pc_d      = fetch_pc_q;
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        // A redirect orphans an in-flight request whose data has not yet come back.
        if (resp) begin
            discard_d = 1'b0;
        end else if (PCSrcE && outstanding_q) begin
            discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (PCSrcE),
        .count     (count),
        .head      (head)
    );

    assign imem_req  = req;
    assign imem_addr = fetch_pc_q;
    assign ValidD    = valid;
    assign InstrD    = valid ? head.instr : NOP_INSTR;
    assign PCD       = valid ? head.pc : '0;
    assign PCPlus4D  = valid ? head.pc + XLEN'(4) : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] drop_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (push) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (drop) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    assign FetchCount = fetch_count_q;
    assign DropCount  = drop_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a memory model with random latency/ready,
// directed timing scenarios, then randomized stalls and redirects.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] drop_count;
    logic [31:0] drop_base;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(32),
        .DEPTH(2),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallD     (StallD),
        .ValidD     (ValidD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (fetch_count),
        .DropCount  (drop_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    // Expected architectural PC stream: target, target+4, ... after each reset/redirect.
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    bit          mon_en = 1'b0;

    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rdy_pct = 100;
    bit          force_stray;
    bit          acc_flag;
    logic [31:0] acc_addr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock: drive inputs just after the edge, sample the memory handshake mid-cycle.
    task automatic cyc(input bit rst, input bit redir, input logic [31:0] tgt, input bit stall);
        @(posedge clk);
        #1;
        reset     = rst;
        PCSrcE    = redir;
        PCTargetE = tgt;
        StallD    = stall;
        acc_flag  = 1'b0;
        if (rst) begin
            mem_pend = 1'b0;
            exp_q.delete();
            exp_next = RESET_PC;
        end
        if (redir) begin
            exp_q.delete();
            exp_next = tgt & ~32'h3;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next += 32'd4;
        end
        if (force_stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            force_stray = 1'b0;
        end else if (mem_pend && mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(mem_addr);
            mem_pend    = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_pend) mem_wait--;
        end
        imem_ready = ($urandom_range(0, 99) < rdy_pct);
        @(negedge clk);
        if (!reset && imem_req && imem_ready) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            mem_wait = int'($urandom_range(lat_min, lat_max)) - 1;
            acc_flag = 1'b1;
            acc_addr = imem_addr;
        end
    endtask

    // Monitor: compares the decode-stage head with the scoreboard every cycle.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
            if (ValidD && !PCSrcE) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    check("head_pc", PCD, exp_q[0]);
                    check("head_instr", InstrD, memfn(exp_q[0]));
                    check("head_pc4", PCPlus4D, exp_q[0] + 32'd4);
                    if (!StallD) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end else if (!ValidD) begin
                check("idle_instr", InstrD, NOP);
                check("idle_pcd", PCD, 32'h0);
                check("idle_pc4", PCPlus4D, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] hold;
        bit          found;
        bit          saw;
        int          pops_before;

        reset = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        mem_pend = 1'b0; force_stray = 1'b0;

        repeat (3) cyc(1, 0, 0, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", ValidD, 0);
        check("rst_instr", InstrD, NOP);
        check("rst_pcd", PCD, 0);
        check("rst_pc4", PCPlus4D, 0);
`ifdef FETCH_PERF_EN
        check("rst_fetchcnt", fetch_count, 0);
        check("rst_dropcnt", drop_count, 0);
`endif
        mon_en = 1'b1;

        // Reset release timing with a 1-cycle memory
        cyc(0, 0, 0, 0);
        check("c0_req", imem_req, 1);
        check("c0_addr", imem_addr, RESET_PC);
        check("c0_valid", ValidD, 0);
        cyc(0, 0, 0, 0);
        check("c1_valid", ValidD, 0);
        cyc(0, 0, 0, 0);
        check("c2_valid", ValidD, 1);
        check("c2_pcd", PCD, RESET_PC);
`ifdef FETCH_PERF_EN
        check("c2_fetchcnt", fetch_count, 1);
`endif
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, 0);
            check("stream_valid", ValidD, 1);
        end

        // Decode stall: queue fills, request drops, head held
        cyc(0, 0, 0, 1);
        hold = InstrD;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1);
            check("stall_hold", InstrD, hold);
            check("stall_req", imem_req, 0);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0);
            check("release_valid", ValidD, 1);
        end

        // Redirect while a slow request is in flight
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(0, 0, 0, 0);
            if (acc_flag) found = 1'b1;
        end
        check("slow_acc_seen", found, 1);
`ifdef FETCH_PERF_EN
        drop_base = drop_count;
`endif
        lat_min = 1; lat_max = 1;
        cyc(0, 1, 32'h0000_0200, 0);
        check("redir_req", imem_req, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(0, 0, 0, 0);
            if (acc_flag) begin
                found = 1'b1;
                check("redir_addr", acc_addr, 32'h0000_0200);
            end
        end
        check("redir_acc_seen", found, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(0, 0, 0, 0);
            if (ValidD) begin
                found = 1'b1;
                check("redir_pcd", PCD, 32'h0000_0200);
            end
        end
        check("redir_valid_seen", found, 1);
`ifdef FETCH_PERF_EN
        check("redir_dropcnt", drop_count, drop_base + 32'd1);
`endif

        // Redirect in the same cycle the response arrives
        repeat (3) cyc(0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        drop_base = drop_count;
`endif
        cyc(0, 1, 32'h0000_0300, 0);
        check("sc_req", imem_req, 0);
        cyc(0, 0, 0, 0);
        check("sc_n1_valid", ValidD, 0);
        check("sc_n1_req", imem_req, 1);
        check("sc_n1_addr", imem_addr, 32'h0000_0300);
        cyc(0, 0, 0, 0);
        check("sc_n2_valid", ValidD, 0);
`ifdef FETCH_PERF_EN
        check("sc_dropcnt", drop_count, drop_base + 32'd1);
`endif
        cyc(0, 0, 0, 0);
        check("sc_n3_valid", ValidD, 1);
        check("sc_n3_pcd", PCD, 32'h0000_0300);

        // Address wrap; low target bits must be ignored
        cyc(0, 1, 32'hFFFF_FFFB, 0);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            if (ValidD && PCD == 32'hFFFF_FFFC) begin
                saw = 1'b1;
                check("wrap_pc4", PCPlus4D, 32'h0);
            end
        end
        check("wrap_seen", saw, 1);

        // Reset with a request outstanding, then a stray response
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(0, 0, 0, 0);
            if (acc_flag) found = 1'b1;
        end
        check("mid_acc_seen", found, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("mid_rst_valid", ValidD, 0);
        check("mid_rst_req", imem_req, 0);
        lat_min = 1; lat_max = 1;
        force_stray = 1'b1;
        rdy_pct = 0;
        cyc(0, 0, 0, 0);
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, RESET_PC);
        rdy_pct = 100;
        cyc(0, 0, 0, 0);
        check("stray_valid", ValidD, 0);
        check("post_rst_acc", acc_addr, RESET_PC);
        cyc(0, 0, 0, 0);
        check("post_rst_v2", ValidD, 0);
        cyc(0, 0, 0, 0);
        check("post_rst_v3", ValidD, 1);
        check("post_rst_pcd", PCD, RESET_PC);

        // Randomized traffic
        rdy_pct = 70; lat_min = 1; lat_max = 4;
        pops_before = pops;
        for (int i = 0; i < 1500; i++) begin
            cyc(0, ($urandom_range(0, 99) < 3), $urandom, ($urandom_range(0, 99) < 25));
        end
        check("rand_progress", ((pops - pops_before) > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the fetch PC, issues word requests to instruction memory over a request/response handshake, and buffers returned instructions in a small queue. The queue head is the IF/ID register driving InstrD into the decode-stage controller. Execute-stage branch/jump redirects (PCSrcE) flush the queue and restart fetch at PCTargetE.

## Interface
Parameters:
- XLEN, 32, address/data width.
- DEPTH, 2, queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk, input, 1, pipeline clock; one clock domain.
- reset, input, 1, synchronous, active-high.
- imem_req, output, 1, fetch request valid.
- imem_addr, output, XLEN, word address of the request; always 4-byte aligned.
- imem_ready, input, 1, memory accepts the request this cycle.
- imem_rvalid, input, 1, read data valid; in-order; at most one response per accepted request.
- imem_rdata, input, XLEN, instruction word.
- PCSrcE, input, 1, redirect from execute.
- PCTargetE, input, XLEN, redirect target; bits [1:0] are ignored and treated as 0.
- StallD, input, 1, hazard unit holds decode.
- ValidD, output, 1, queue head is a live instruction.
- InstrD, output, XLEN, queue head instruction; 32'h0000_0013 (NOP) when ValidD=0.
- PCD, output, XLEN, PC of InstrD; 0 when ValidD=0.
- PCPlus4D, output, XLEN, PCD+4; 0 when ValidD=0.
- FetchCount, output, 32, present only with FETCH_PERF_EN.
- DropCount, output, 32, present only with FETCH_PERF_EN.

## Operation
- State: FetchPC, Outstanding (0/1), ReqPC, Discard, and the queue with its Count.
- Pop = ValidD && !StallD && !PCSrcE. Pop removes the head.
- Issue: imem_req = !PCSrcE && (!Outstanding || imem_rvalid) && (Count + Outstanding − Pop) < DEPTH. imem_addr = FetchPC.
- Accept (imem_req && imem_ready): Outstanding←1, ReqPC←FetchPC, FetchPC←FetchPC+4 (mod 2^XLEN, wraps).
- Response (imem_rvalid && Outstanding): if Discard or PCSrcE, the response is dropped and Discard←0. Otherwise {ReqPC, imem_rdata} is pushed. Outstanding←0 unless a new accept occurs in the same cycle.
- imem_rvalid with Outstanding=0 is ignored.
- Redirect (PCSrcE=1): the queue is emptied, FetchPC←{PCTargetE[XLEN-1:2],2'b00}, and no request is issued that cycle. If a request is outstanding and its response is not arriving this cycle, Discard←1.
- Priority: reset > PCSrcE > StallD. Push and Pop may occur in the same cycle; Count is unchanged.
- Full queue: no issue. Empty queue: ValidD=0 and NOP is presented.
- Reset values: imem_req=0, imem_addr=RESET_PC, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0, Count=0, Outstanding=0, Discard=0, FetchPC=RESET_PC, counters=0.
- Reset asserted mid-transaction abandons the in-flight request. A late imem_rvalid after reset is ignored because Outstanding=0.

## Timing
- imem_req is combinational from state, PCSrcE, StallD and imem_rvalid. There is no combinational path from imem_rdata to any output.
- Pushed entries are visible on ValidD/InstrD the cycle after imem_rvalid.
- Reset deasserted in cycle 0 → imem_req=1, addr=RESET_PC in cycle 0. With a 1-cycle memory, rvalid arrives in cycle 1 and ValidD=1 in cycle 2.
- Steady state with a 1-cycle memory, DEPTH≥2 and no stalls: one instruction per cycle.
- Redirect in cycle n → new-target request in cycle n+1 at the earliest. With a 1-cycle memory, the target instruction reaches ValidD in cycle n+3.

## Configuration
- FETCH_PERF_EN defined: the FetchCount and DropCount ports exist.
  - FetchCount increments on each push.
  - DropCount increments on each dropped response.
  - Both are 32-bit wrapping counters, cleared by reset.
- FETCH_PERF_EN undefined: the ports and counter logic are absent; behaviour is otherwise identical.

## Structure
- Shared package riscv_pkg holds:
  - the NOP_INSTR constant (32'h0000_0013);
  - the XLEN default;
  - typedef fetch_entry_t, a packed struct {pc, instr}.
- Sub-module fetch_queue is a synchronous FIFO of fetch_entry_t with DEPTH entries.
  - Ports: push, pop, flush, count, head.
  - Read is first-word-fall-through.
  - flush has priority over push.

## Test plan
- Reset, 1-cycle memory returning addr-as-data, StallD=0 → PCD runs 0,4,8,…. One ValidD per cycle from cycle 2. InstrD equals PCD.
- StallD=1 for 3 cycles with DEPTH=2 → queue fills to 2 and imem_req drops. InstrD is held constant. On release, the sequence continues with no gap or duplicate.
- Request to 0x10 accepted, PCSrcE=1 with PCTargetE=0x200 before rvalid → the response for 0x10 is dropped (DropCount=1). The next request is 0x200 and the next ValidD shows PCD=0x200.
- PCSrcE in the same cycle as imem_rvalid → the response is dropped, the queue is empty next cycle, and no request is issued in the redirect cycle.
- RESET_PC=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. PCPlus4D for FFFF_FFFC is 0.
- Reset asserted with a request outstanding, then a stray imem_rvalid → ValidD stays 0 and the first post-reset request is RESET_PC.
